pc_trace: RTL



---
 rtl/pc_trace.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/pc_trace.sv
// -----------------------------------------------------------------------------
// pc_trace -- program-counter trace buffer.
//
// Samples the core PC every cycle and records each change of PC, together with
// a cycle timestamp, into a circular buffer of DEPTH entries. When the buffer
// is full, a new capture overwrites the oldest entry and sets a sticky
// overflow flag. Entries are drained oldest-first through a first-word-fall-
// through pop port. A sticky hang detector raises `stall` once STALL_LIMIT
// cycles have passed without a capture.
//
// Optional feature (macro PC_TRACE_TIMESTAMP_EN):
//   defined   -> free-running cycle counter and per-entry timestamps exist.
//   undefined -> both are omitted; `cycle` and `rd_cycle` are tied to 0.
//                The stall detector keeps its own counter either way.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   pc        in   PC from the core (ADDR_W)
//   pc_valid  in   `pc` is meaningful this cycle
//   clear     in   synchronous flush of buffer and sticky flags
//   rd_en     in   pop the head entry (ignored when empty)
//   rd_valid  out  buffer not empty; rd_pc / rd_cycle are valid
//   rd_pc     out  PC of the head (oldest) entry, combinational
//   rd_cycle  out  timestamp of the head entry, combinational
//   count     out  number of stored entries ($clog2(DEPTH)+1 bits)
//   overflow  out  sticky: an entry was overwritten
//   stall     out  sticky: STALL_LIMIT cycles without a capture
//   cycle     out  free-running cycle counter (CYCLE_W)
// -----------------------------------------------------------------------------
module pc_trace #(
  parameter int ADDR_W      = 64,
  parameter int DEPTH       = 16,   // power of two, >= 2
  parameter int CYCLE_W     = 32,
  parameter int STALL_LIMIT = 256   // 1 .. 2^CYCLE_W-1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     pc_valid,
  input  logic                     clear,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [ADDR_W-1:0]        rd_pc,
  output logic [CYCLE_W-1:0]       rd_cycle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     stall,
  output logic [CYCLE_W-1:0]       cycle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CYCLE_W-1:0] STALL_MAX = CYCLE_W'(STALL_LIMIT);

  // Control state.
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               stall_q, stall_d;
  logic [CYCLE_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               have_last_q, have_last_d;
  logic [ADDR_W-1:0]  last_pc_q, last_pc_d;

  // Entry storage.
  logic [ADDR_W-1:0]  pc_mem_q [DEPTH];

  logic capture;
  logic is_full;
  logic is_empty;
  logic pop;
  logic push;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    stall_d     = stall_q;
    stall_cnt_d = stall_cnt_q;
    have_last_d = have_last_q;
    last_pc_d   = last_pc_q;

    // A capture happens only on a PC change, or on the first valid PC after
    // reset/clear when there is nothing to compare against.
    capture  = pc_valid && (!have_last_q || (pc != last_pc_q));
    is_full  = (count_q == FULL_CNT);
    is_empty = (count_q == '0);
    pop      = rd_en && !is_empty;
    push     = capture && !clear;

    if (clear) begin
      // Flush wins over any capture or pop this cycle.
      head_d      = tail_q;
      count_d     = '0;
      overflow_d  = 1'b0;
      stall_d     = 1'b0;
      stall_cnt_d = '0;
      have_last_d = 1'b0;
    end else begin
      if (capture) begin
        tail_d      = tail_q + 1'b1;
        last_pc_d   = pc;
        have_last_d = 1'b1;
        stall_cnt_d = '0;
        if (is_full) begin
          // The oldest entry leaves either way: popped if rd_en, overwritten
          // otherwise. Only the overwrite counts as an overflow.
          head_d = head_q + 1'b1;
          if (!pop) begin
            overflow_d = 1'b1;
          end
        end else if (pop) begin
          head_d = head_q + 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (pop) begin
          head_d  = head_q + 1'b1;
          count_d = count_q - 1'b1;
        end
        if (stall_cnt_q != STALL_MAX) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end

      if (stall_cnt_d == STALL_MAX) begin
        stall_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      stall_q     <= 1'b0;
      stall_cnt_q <= '0;
      have_last_q <= 1'b0;
      last_pc_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      stall_q     <= stall_d;
      stall_cnt_q <= stall_cnt_d;
      have_last_q <= have_last_d;
      last_pc_q   <= last_pc_d;
    end
  end

  // NOTE: the storage is reset because the read port is combinational from
  // it; clearing it is what makes rd_pc / rd_cycle read 0 straight out of
  // reset without a separate output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[tail_q] <= pc;
    end
  end

  assign rd_valid = !is_empty;
  assign rd_pc    = pc_mem_q[head_q];
  assign count    = count_q;
  assign overflow = overflow_q;
  assign stall    = stall_q;

`ifdef PC_TRACE_TIMESTAMP_EN
  // ---------------------------------------------------------------------------
  // Cycle counter and timestamp storage
  // ---------------------------------------------------------------------------
  logic [CYCLE_W-1:0] cycle_q;
  logic [CYCLE_W-1:0] ts_mem_q [DEPTH];

  // Wraps modulo 2^CYCLE_W; clear deliberately leaves it running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
    end
  end

  // Timestamp is the counter value before the capturing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ts_mem_q[i] <= '0;
      end
    end else if (push) begin
      ts_mem_q[tail_q] <= cycle_q;
    end
  end

  assign cycle    = cycle_q;
  assign rd_cycle = ts_mem_q[head_q];
`else
  assign cycle    = '0;
  assign rd_cycle = '0;
`endif

endmodule
